sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

SHA-256 message-schedule generator: accepts one 512-bit padded block as sixteen 32-bit words and emits the 64 schedule words W0..W63, one per cycle, with a round index. It sits upstream of the compression round logic and produces the per-round word that drives the working-variable / hash-accumulator registers. It marks the final word with `eoc` so the accumulators perform the H += working-variable addition.

## Interface
Parameters:
- `ROUNDS`, 64, schedule length; fixed by SHA-256, not meant to be overridden.
- `LOAD_WORDS`, 16, message words per block.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `soc`  in  1  start of block; one-cycle pulse, honoured only in IDLE.
- `in_valid`  in  1  `in_word` valid.
- `in_word`  in  32  message word, big-endian word order (M0 first).
- `in_ready`  out  1  scheduler accepts a word this cycle (high only in LOAD).
- `w_valid`  out  1  `w_out`/`t_out` valid this cycle.
- `w_out`  out  32  schedule word W_t.
- `t_out`  out  6  round index t of `w_out`.
- `eoc`  out  1  one-cycle pulse coincident with `w_valid` for t=63.
- `busy`  out  1  high in LOAD and GEN.

## Operation
- States: IDLE, LOAD, GEN.
- IDLE: `in_ready`=0; `soc`=1 -> LOAD, round counter cleared to 0.
- LOAD: `in_ready`=1; word accepted on `in_valid & in_ready`. Each accepted word is shifted into a 16-entry window (W[t-16]..W[t-1]) and emitted as W_t=M_t next cycle. Gaps on `in_valid` produce `w_valid`=0 cycles; counter holds. After the 16th acceptance -> GEN.
- GEN: one word per cycle, no stalls. W_t = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32, carries discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Each W_t is shifted into the window and registered to `w_out`. After W63 is computed -> IDLE.
- No output back-pressure: the consumer must take every `w_valid` word.
- `soc` in LOAD/GEN is ignored; there is no error flag.
- `in_valid` outside LOAD is ignored.
- `rst` at any time: state IDLE, counter 0, window cleared. A partially emitted block is abandoned, with no `eoc`.
- `soc` and `rst` in the same cycle: `rst` wins.

## Timing
- Reset values: `in_ready`=0, `w_valid`=0, `w_out`=0, `t_out`=0, `eoc`=0, `busy`=0.
- `soc` at cycle n: `in_ready`=1 and `busy`=1 from n+1.
- Load latency: word accepted at edge k appears on `w_out` with `w_valid` in cycle k+1.
- GEN timing: with back-to-back input, W15 appears at cycle n+17 and W16..W63 at n+18..n+65.
- Full block with back-to-back input: 64 consecutive `w_valid` cycles.
- `eoc` is high only in the t=63 cycle; `busy` falls the cycle after.
- A new `soc` is accepted the cycle after `eoc` (cycle n+66 at the earliest).
- `t_out` is monotonic 0..63 and never wraps within a block.
- Critical path: the σ1 + 3-input + 2-operand add. A single cycle is required; no internal pipelining.

## Structure
- Shared package `sha256_pkg`:
  - `WORD_W`=32, `ROUNDS`=64, `LOAD_WORDS`=16.
  - State enum {IDLE, LOAD, GEN}.
  - σ0/σ1 rotate/shift amounts.
- Sub-module `sha256_ssig`:
  - Combinational small-sigma.
  - Parameterised by the three amounts; instantiated twice (σ0, σ1).
  - Shared with any future scheduler variant.
- Window is a 16×32 shift register, not a RAM.

## Test plan
- "abc" block, back-to-back input (W0=0x61626380, W1..W14=0, W15=0x00000018) -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB. `eoc` with t=63; 64 contiguous `w_valid` cycles.
- Same block with `in_valid` dropped on words 3 and 9 for 2 cycles each -> identical W sequence; `w_valid` low for exactly 4 cycles; `t_out` never skips.
- `soc` pulsed during GEN at t=30 -> ignored; sequence and `eoc` timing unchanged.
- `rst` asserted at t=40 -> next cycle all outputs 0, no `eoc`. A subsequent `soc` + "abc" block reproduces the golden sequence.
- Two blocks back to back (`soc` the cycle after `eoc`), second block = all-0xFFFFFFFF words -> W0..W15 all 0xFFFFFFFF; W16..W63 match the software model; no residue from block 1.
- `soc`+`rst` same cycle, and `in_valid` high while IDLE -> stays IDLE, `in_ready`=0, no `w_valid`.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, scheduler state encoding and small-sigma
// rotate/shift amounts.
package sha256_pkg;

  localparam int WORD_W     = 32;
  localparam int ROUNDS     = 64;
  localparam int LOAD_WORDS = 16;
  // Counter must represent ROUNDS itself (the drain cycle after W63).
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GEN  = 2'd2
  } state_e;

  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

endpackage

// File: rtl/sha256_ssig.sv
// Combinational SHA-256 small-sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(SH).
module sha256_ssig
  import sha256_pkg::*;
#(
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int SH = 3
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  always_comb begin
    y = ((x >> R1) | (x << (WORD_W - R1)))
      ^ ((x >> R2) | (x << (WORD_W - R2)))
      ^ (x >> SH);
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads M0..M15 into a 16-word window, then
// expands W16..W63 at one word per cycle; eoc marks W63.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS     = sha256_pkg::ROUNDS,
  parameter int LOAD_WORDS = sha256_pkg::LOAD_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soc,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              w_valid,
  output logic [WORD_W-1:0] w_out,
  output logic [5:0]        t_out,
  output logic              eoc,
  output logic              busy,
  output state_e            dbg_state
);

  // Handshake: a word moves on in_valid & in_ready; outputs have no
  // back-pressure, so every cycle with w_valid high carries a new W_t.

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  // win[0] is the oldest word W[t-16], win[LOAD_WORDS-1] the newest W[t-1].
  logic [WORD_W-1:0]  win [LOAD_WORDS];
  logic               accept, gen_en, load_last, push;
  logic [WORD_W-1:0]  s0, s1, w_new, next_word;

  assign accept    = (state == ST_LOAD) && in_valid;
  assign gen_en    = (state == ST_GEN) && (cnt != CNT_W'(ROUNDS));
  assign load_last = accept && (cnt == CNT_W'(LOAD_WORDS - 1));
  assign push      = accept || gen_en;

  sha256_ssig #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_sig0 (
    .x (win[1]),
    .y (s0)
  );

  sha256_ssig #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_sig1 (
    .x (win[LOAD_WORDS-2]),
    .y (s1)
  );

  always_comb begin
    w_new     = s1 + win[LOAD_WORDS-7] + s0 + win[0];
    next_word = accept ? in_word : w_new;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (soc)       state_nxt = ST_LOAD;
      ST_LOAD: if (load_last) state_nxt = ST_GEN;
      // One drain cycle after W63 keeps busy high through the eoc cycle.
      ST_GEN:  if (cnt == CNT_W'(ROUNDS)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_LOAD);
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      w_valid <= 1'b0;
      w_out   <= '0;
      t_out   <= '0;
      eoc     <= 1'b0;
      for (int i = 0; i < LOAD_WORDS; i++) win[i] <= '0;
    end else begin
      w_valid <= push;
      eoc     <= gen_en && (cnt == CNT_W'(ROUNDS - 1));
      if ((state == ST_IDLE) && soc) cnt <= '0;
      else if (push)                 cnt <= cnt + 1'b1;
      if (push) begin
        for (int i = 0; i < LOAD_WORDS - 1; i++) win[i] <= win[i+1];
        win[LOAD_WORDS-1] <= next_word;
        w_out <= next_word;
        t_out <= cnt[5:0];
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: randomized and directed blocks
// against a schedule model computed from the SHA-256 recurrence.
module tb_sha256_msg_sched;
  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst, soc, in_valid;
  logic [31:0] in_word;
  logic        in_ready, w_valid, eoc, busy;
  logic [31:0] w_out;
  logic [5:0]  t_out;
  state_e      dbg_state;

  sha256_msg_sched dut (
    .clk(clk), .rst(rst), .soc(soc), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .w_valid(w_valid), .w_out(w_out), .t_out(t_out),
    .eoc(eoc), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  logic [31:0] msg   [16];
  logic [31:0] ref_w [64];
  logic [31:0] got_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
    logic [63:0] d;
    d = {x, x} >> r;
    return d[31:0];
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void compute_ref();
    logic [63:0] s;
    for (int t = 0; t < 16; t++) ref_w[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s = 64'(sig1(ref_w[t-2])) + 64'(ref_w[t-7]) + 64'(sig0(ref_w[t-15])) + 64'(ref_w[t-16]);
      ref_w[t] = s[31:0];
    end
  endfunction

  // scoreboard
  logic [31:0] exp_q[$];
  int mon_t = 0;
  int valid_cnt = 0;
  int eoc_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("eoc", {31'b0, eoc},
            {31'b0, (w_valid && exp_q.size() != 0 && mon_t == 63)});
      if (w_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("w_valid_unexp", {31'b0, w_valid}, 32'd0);
        end else begin
          check("w_out", w_out, exp_q.pop_front());
          check("t_out", {26'b0, t_out}, mon_t);
          if (mon_t < 64) got_w[mon_t] = w_out;
          if (eoc) eoc_seen++;
          mon_t++;
        end
      end
    end
  end

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int p0, input int p1, input int glen,
                           input bit mid_soc, input bit abort, input int exp_lat);
    int soc_cyc;
    bit done;
    int k;
    compute_ref();
    exp_q.delete();
    for (int t = 0; t < 64; t++) exp_q.push_back(ref_w[t]);
    mon_t = 0; valid_cnt = 0; eoc_seen = 0;
    soc = 1'b1; soc_cyc = cyc;
    tick();
    soc = 1'b0;
    check("soc_in_ready", {31'b0, in_ready}, 32'd1);
    check("soc_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == p0 || i == p1) begin
        in_valid = 1'b0;
        repeat (glen) tick();
      end
      in_valid = 1'b1;
      in_word  = msg[i];
      tick();
    end
    in_valid = 1'b0;
    in_word  = $urandom;
    done = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      if (abort && w_valid && t_out == 6'd40) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_w_valid", {31'b0, w_valid}, 32'd0);
        check("abort_w_out", w_out, 32'd0);
        check("abort_t_out", {26'b0, t_out}, 32'd0);
        check("abort_eoc", {31'b0, eoc}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        check("abort_no_eoc", eoc_seen, 32'd0);
        exp_q.delete();
        return;
      end
      if (eoc) begin
        done = 1'b1;
      end else begin
        soc = mid_soc && w_valid && (t_out == 6'd30);
        tick();
        k++;
      end
    end
    soc = 1'b0;
    if (!done) begin
      check("eoc_timeout", 32'd0, 32'd1);
      return;
    end
    check("eoc_latency", cyc - soc_cyc, exp_lat);
    tick();
    check("busy_after_eoc", {31'b0, busy}, 32'd0);
    check("valid_count", valid_cnt, 32'd64);
    check("eoc_count", eoc_seen, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic check_golden(input string tag);
    check({tag, "_w15"}, got_w[15], 32'h00000018);
    check({tag, "_w16"}, got_w[16], 32'h61626380);
    check({tag, "_w17"}, got_w[17], 32'h000F0000);
    check({tag, "_w63"}, got_w[63], 32'h12B1EDEB);
  endtask

  initial begin
    int p0, p1, gl, lat;
    rst = 1'b1; soc = 1'b0; in_valid = 1'b0; in_word = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_w_valid", {31'b0, w_valid}, 32'd0);
    check("rst_w_out", w_out, 32'd0);
    check("rst_t_out", {26'b0, t_out}, 32'd0);
    check("rst_eoc", {31'b0, eoc}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    tick();

    // "abc" block, back-to-back input
    load_abc();
    run_block(-1, -1, 0, 1'b0, 1'b0, 65);
    check_golden("abc");

    // same block with 2-cycle gaps before words 3 and 9
    run_block(3, 9, 2, 1'b0, 1'b0, 69);
    check_golden("gaps");

    // soc during GEN is ignored
    run_block(-1, -1, 0, 1'b1, 1'b0, 65);
    check_golden("midsoc");

    // reset at t=40 abandons the block, then a clean rerun
    run_block(-1, -1, 0, 1'b0, 1'b1, 0);
    run_block(-1, -1, 0, 1'b0, 1'b0, 65);
    check_golden("after_rst");

    // back-to-back: all-ones block starts the cycle after eoc
    for (int i = 0; i < 16; i++) msg[i] = 32'hFFFFFFFF;
    run_block(-1, -1, 0, 1'b0, 1'b0, 65);

    // randomized blocks with random gaps
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      p0  = $urandom_range(0, 15);
      p1  = $urandom_range(0, 15);
      gl  = $urandom_range(0, 3);
      lat = 65 + ((p0 == p1) ? gl : 2 * gl);
      run_block(p0, p1, gl, 1'b0, 1'b0, lat);
    end

    // soc and rst together, then in_valid while idle
    exp_q.delete();
    rst = 1'b1; soc = 1'b1;
    tick();
    rst = 1'b0; soc = 1'b0;
    check("socrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("socrst_busy", {31'b0, busy}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_word = $urandom;
      tick();
      check("idle_in_ready", {31'b0, in_ready}, 32'd0);
      check("idle_w_valid", {31'b0, w_valid}, 32'd0);
      check("idle_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    end
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
